// File: rtl/mx_int8_pkg.sv
// Shared FP32 field layout, MXINT8 constants and controller state type.
// Used by mx_int8_block_enc_ctrl and mx_int8_elem_quant.
package mx_int8_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  localparam int ELEM_W_DEF  = 8;
  localparam int SCALE_W_DEF = 8;

  localparam logic [7:0] NAN_SCALE   = 8'hFF;
  localparam logic [7:0] EXP_SPECIAL = 8'hFF;
  localparam int         ELEM_MAX    = 127;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    QUANT,
    OUT
  } state_t;

  // Subnormals share the exponent of the smallest normal.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? 8'd1 : e;
  endfunction

endpackage

// File: rtl/mx_int8_elem_quant.sv
// Combinational FP32 -> MXINT8 element quantizer against a shared exponent.
// Round-to-nearest-even, clamps to +/-ELEM_MAX and flags saturation.
module mx_int8_elem_quant
  import mx_int8_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic [FP_W-1:0]   i_float32,
  input  logic [EXP_W-1:0]  i_shared_exp,
  output logic [ELEM_W-1:0] o_elem,
  output logic              o_sat
);

  localparam int          BASE_SH = MAN_W - (ELEM_W - 2);
  localparam logic [23:0] MAXV    = 24'((1 << (ELEM_W - 1)) - 1);

  logic [EXP_W-1:0]  e_eff;
  logic [23:0]       sig;
  logic [8:0]        d;
  logic [9:0]        sh;
  logic [47:0]       ext;
  logic [23:0]       kept;
  logic [23:0]       rnd;
  logic              guard;
  logic              sticky;
  logic              up;
  logic [ELEM_W-1:0] mag;

  always_comb begin
    e_eff  = eff_exp(i_float32[EXP_MSB:EXP_LSB]);
    sig    = {|i_float32[EXP_MSB:EXP_LSB], i_float32[MAN_MSB:0]};
    d      = {1'b0, i_shared_exp} - {1'b0, e_eff};
    sh     = 10'(BASE_SH) + {1'b0, d};
    ext    = '0;
    // Low half of ext holds the dropped bits for guard/sticky.
    if (sh < 10'd25) ext = {sig, 24'b0} >> sh;
    kept   = ext[47:24];
    guard  = ext[23];
    sticky = |ext[22:0];
    up     = guard & (sticky | kept[0]);
    rnd    = kept + {23'b0, up};
    o_sat  = (rnd > MAXV);
    mag    = o_sat ? MAXV[ELEM_W-1:0] : rnd[ELEM_W-1:0];
    o_elem = i_float32[SIGN_BIT] ? -mag : mag;
  end

endmodule

// File: rtl/mx_int8_block_enc_ctrl.sv
// FP32 stream -> one MXINT8 block: collect, quantize, present on valid/ready.
// Optional perf counters under `define MX_INT8_BD_PERF_CNT_EN.
module mx_int8_block_enc_ctrl
  import mx_int8_pkg::*;
#(
  parameter int BLOCK_SIZE = 32,
  parameter int ELEM_W     = ELEM_W_DEF,
  parameter int SCALE_W    = SCALE_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [FP_W-1:0]    i_float32,
  input  logic               i_valid,
  input  logic               i_last,
  output logic               o_ready,
  output logic [SCALE_W-1:0] o_scale,
  output logic [ELEM_W-1:0]  o_mxint8_elements [BLOCK_SIZE],
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_sat,
  output logic               o_busy
`ifdef MX_INT8_BD_PERF_CNT_EN
  ,
  output logic [31:0]        o_blk_cnt,
  output logic [31:0]        o_sat_cnt
`endif
);

  localparam int IDX_W = $clog2(BLOCK_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   q_q, q_d;
  logic [EXP_W-1:0]   maxexp_q, maxexp_d;
  logic               nan_q, nan_d;
  logic               sat_q, sat_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic [FP_W-1:0]    data_q [BLOCK_SIZE];
  logic [FP_W-1:0]    data_d [BLOCK_SIZE];
  logic [ELEM_W-1:0]  elems_q [BLOCK_SIZE];
  logic [ELEM_W-1:0]  elems_d [BLOCK_SIZE];
`ifdef MX_INT8_BD_PERF_CNT_EN
  logic [31:0]        blk_cnt_q, blk_cnt_d;
  logic [31:0]        sat_cnt_q, sat_cnt_d;
`endif

  logic [ELEM_W-1:0]  q_elem;
  logic               q_sat;
  logic [EXP_W-1:0]   in_exp;
  logic [EXP_W-1:0]   in_eff;

  mx_int8_elem_quant #(
    .ELEM_W (ELEM_W)
  ) u_quant (
    .i_float32    (data_q[q_q]),
    .i_shared_exp (maxexp_q),
    .o_elem       (q_elem),
    .o_sat        (q_sat)
  );

  assign in_exp = i_float32[EXP_MSB:EXP_LSB];
  assign in_eff = eff_exp(in_exp);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    q_d      = q_q;
    maxexp_d = maxexp_q;
    nan_d    = nan_q;
    sat_d    = sat_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    scale_d  = scale_q;
    data_d   = data_q;
    elems_d  = elems_q;
`ifdef MX_INT8_BD_PERF_CNT_EN
    blk_cnt_d = blk_cnt_q;
    sat_cnt_d = sat_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        for (int i = 0; i < BLOCK_SIZE; i++) data_d[i] = '0;
        maxexp_d = '0;
        nan_d    = 1'b0;
        sat_d    = 1'b0;
        idx_d    = '0;
        q_d      = '0;
        ready_d  = 1'b1;
        state_d  = COLLECT;
      end
      COLLECT: begin
        if (i_valid && ready_q) begin
          data_d[idx_q] = i_float32;
          idx_d = idx_q + 1'b1;
          // Inf/NaN never contributes to the shared exponent.
          if (in_exp == EXP_SPECIAL) nan_d = 1'b1;
          else if (in_eff > maxexp_q) maxexp_d = in_eff;
          if (idx_q == LAST_IDX || i_last) begin
            ready_d = 1'b0;
            state_d = QUANT;
          end
        end
      end
      QUANT: begin
        elems_d[q_q] = nan_q ? '0 : q_elem;
        if (!nan_q && q_sat) begin
          sat_d = 1'b1;
`ifdef MX_INT8_BD_PERF_CNT_EN
          sat_cnt_d = sat_cnt_q + 32'd1;
`endif
        end
        q_d = q_q + 1'b1;
        if (q_q == LAST_IDX) begin
          scale_d = nan_q ? SCALE_W'(NAN_SCALE) : SCALE_W'(maxexp_q);
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
`ifdef MX_INT8_BD_PERF_CNT_EN
          blk_cnt_d = blk_cnt_q + 32'd1;
`endif
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      q_q      <= '0;
      maxexp_q <= '0;
      nan_q    <= 1'b0;
      sat_q    <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      scale_q  <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        data_q[i]  <= '0;
        elems_q[i] <= '0;
      end
`ifdef MX_INT8_BD_PERF_CNT_EN
      blk_cnt_q <= '0;
      sat_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      q_q      <= q_d;
      maxexp_q <= maxexp_d;
      nan_q    <= nan_d;
      sat_q    <= sat_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      scale_q  <= scale_d;
      data_q   <= data_d;
      elems_q  <= elems_d;
`ifdef MX_INT8_BD_PERF_CNT_EN
      blk_cnt_q <= blk_cnt_d;
      sat_cnt_q <= sat_cnt_d;
`endif
    end
  end

  assign o_ready           = ready_q;
  assign o_valid           = valid_q;
  assign o_busy            = busy_q;
  assign o_scale           = scale_q;
  assign o_sat             = sat_q;
  assign o_mxint8_elements = elems_q;
`ifdef MX_INT8_BD_PERF_CNT_EN
  assign o_blk_cnt = blk_cnt_q;
  assign o_sat_cnt = sat_cnt_q;
`endif

endmodule
